// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the two-requester memory arbiter: FSM state encoding,
// owner (requester) encoding, the latched memory request record and the
// width of the response timeout counter.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    // Wide enough for the largest supported timeout (255).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Two-way round-robin select between the IFU and LSU. When both request,
// the one not granted most recently wins. last_grant only moves on a grant
// and resets to LSU so the IFU wins the first tie.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : arbitration allowed this cycle (arbiter idle)
//   ifu_valid       : IFU is requesting
//   lsu_valid       : LSU is requesting
//   ifu_gnt/lsu_gnt : one-hot grant (combinational)
//   winner          : owner granted this cycle (meaningful with a grant)
// ---------------------------------------------------------------------------
module rr_picker
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    output logic   ifu_gnt,
    output logic   lsu_gnt,
    output owner_e winner
);

    owner_e last_grant;

    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        winner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            winner = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_valid) begin
            winner = OWN_LSU;
        end
        ifu_gnt = en && ifu_valid && (winner == OWN_IFU);
        lsu_gnt = en && lsu_valid && (winner == OWN_LSU);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= OWN_LSU;
        end else if (ifu_gnt || lsu_gnt) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (read only) and a load/store port
// onto a single memory port with one transaction outstanding. A granted
// request is latched and presented in REQ until accepted; RESP then waits
// for the memory response or TIMEOUT cycles, after which an error response
// is returned. Responses are registered and pulsed to the owner only.
//   clk, rst                         : clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr    : IFU read request handshake
//   ifu_resp_valid                   : IFU response pulse
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask    : LSU request handshake and payload
//   lsu_resp_valid                   : LSU response pulse
//   resp_rdata, resp_err             : shared response data / timeout flag
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask    : memory request port
//   mem_resp_valid, mem_rdata        : memory response port
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    // Counter value seen in the last RESP cycle before timing out.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            owner_q;
    mem_req_t          req_q;
    logic [CNT_W-1:0]  cnt_q;

    logic   ifu_gnt, lsu_gnt, any_gnt;
    owner_e winner;
    logic   resp_hit, timeout_hit, done;

    // Gating with rst keeps the ready outputs low while reset is held.
    rr_picker u_rr_picker (
        .clk       (clk),
        .rst       (rst),
        .en        (rst && (state_q == ST_IDLE)),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .ifu_gnt   (ifu_gnt),
        .lsu_gnt   (lsu_gnt),
        .winner    (winner)
    );

    assign any_gnt     = ifu_gnt || lsu_gnt;
    assign resp_hit    = (state_q == ST_RESP) && mem_resp_valid;
    assign timeout_hit = (state_q == ST_RESP) && !mem_resp_valid && (cnt_q == TIMEOUT_LAST);
    assign done        = resp_hit || timeout_hit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_gnt)       state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready) state_d = ST_RESP;
            ST_RESP: if (done)          state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ifu_req_ready = ifu_gnt;
        lsu_req_ready = lsu_gnt;
        mem_req_valid = (state_q == ST_REQ);
    end

    assign mem_addr  = req_q.addr;
    assign mem_wen   = req_q.wen;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    // Request latch, owner, timeout counter and registered response.
    // NOTE: the request/response datapath registers are reset too, so every
    // output reads 0 during reset and nothing of an aborted transaction
    // survives it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q          <= '0;
            owner_q        <= OWN_IFU;
            cnt_q          <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            if (ifu_gnt) begin
                // Fetches are always plain reads.
                req_q   <= '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
                owner_q <= OWN_IFU;
            end else if (lsu_gnt) begin
                req_q   <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                owner_q <= OWN_LSU;
            end

            if (state_q == ST_REQ) begin
                cnt_q <= '0;
            end else if ((state_q == ST_RESP) && !mem_resp_valid) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            ifu_resp_valid <= done && (owner_q == OWN_IFU);
            lsu_resp_valid <= done && (owner_q == OWN_LSU);
            if (done) begin
                resp_rdata <= resp_hit ? mem_rdata : '0;
                resp_err   <= timeout_hit;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 TIMEOUT, default 255, range 1..255: cycles waited in RESP for mem_resp_valid before an error response is returned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-004 ifu_req_valid  input  1  instruction-fetch read request.
REQ-005 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-006 ifu_addr  input  32  IFU read address.
REQ-007 ifu_resp_valid  output  1  one-cycle pulse: IFU response on resp_rdata/resp_err.
REQ-008 lsu_req_valid  input  1  load/store request.
REQ-009 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-010 lsu_addr  input  32  LSU address.
REQ-011 lsu_wen  input  1  1 = store, 0 = load.
REQ-012 lsu_wdata  input  32  store data.
REQ-013 lsu_wmask  input  4  store byte enables.
REQ-014 lsu_resp_valid  output  1  one-cycle pulse: LSU response on resp_rdata/resp_err.
REQ-015 resp_rdata  output  32  response read data, shared by both requesters.
REQ-016 resp_err  output  1  response is a timeout error.
REQ-017 mem_req_valid  output  1  request to the single shared memory port.
REQ-018 mem_req_ready  input  1  memory accepts request.
REQ-019 mem_addr / mem_wen / mem_wdata / mem_wmask  output  32/1/32/4  latched request fields.
REQ-020 mem_resp_valid  input  1  memory response present.
REQ-021 mem_rdata  input  32  memory read data.

Function
REQ-022 FSM states IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-023 IDLE, single valid requester: its req_ready SHALL be 1 combinationally that cycle; owner and request fields latched; next state REQ.
REQ-024 IDLE, both valid: the requester not granted most recently wins (round-robin); only the winner sees req_ready=1; the loser holds valid.
REQ-025 last_grant SHALL update only on a grant; IFU requests carry wen=0, wmask=0, wdata=0.
REQ-026 req_ready SHALL be 0 in REQ and RESP.
REQ-027 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to RESP and clear timeout counter.
REQ-028 RESP: on mem_resp_valid=1 register resp_rdata=mem_rdata, resp_err=0, pulse owner's resp_valid the next cycle, return to IDLE.
REQ-029 RESP: counter increments each cycle without mem_resp_valid; on reaching TIMEOUT, pulse owner's resp_valid with resp_err=1, resp_rdata=0, return to IDLE.
REQ-030 mem_resp_valid in IDLE or REQ (including late responses after timeout) SHALL be ignored.
REQ-031 Latency: grant at cycle t, mem_req_valid at t+1; with ready at t+1 and response at t+2, requester resp_valid at t+3, and a new grant is possible in t+3.
REQ-032 resp_valid SHALL never assert to the non-owner; mem_req_valid SHALL be 0 outside REQ.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, all outputs 0, counter 0, last_grant=LSU (IFU wins the first tie), and discard any in-flight transaction without a response.
REQ-034 The first grant is possible on the first rising edge with rst=1.

Structure
REQ-035 The state encoding and owner encoding (IFU/LSU) SHALL live in the shared core package.
REQ-036 One sub-module, rr_picker (2-way round-robin select with last_grant register), is natural; all else is flat.

Verification
REQ-037 IFU only, addr 0x80000000, mem ready at once, mem_rdata 0x00000297 next cycle -> ifu_resp_valid at t+3 with rdata 0x00000297, err 0.
REQ-038 Both valid at reset exit -> IFU granted first, LSU granted next; under sustained contention grants alternate IFU/LSU.
REQ-039 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_addr/mem_wen/mem_wdata/mem_wmask match and stay stable while mem_req_ready is low 5 cycles.
REQ-040 TIMEOUT=4, no mem_resp_valid -> owner resp_valid with err=1 and rdata 0 after 4 RESP cycles; a late mem_resp_valid is ignored.
REQ-041 rst=0 asserted in RESP -> outputs 0 asynchronously, no resp_valid pulse; after release the next request completes normally.
